// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with a sticky overflow flag.
// Optional almost-full output is enabled by defining UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd,
  input  logic              i_clr_ovf,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
`ifdef UART_RX_FIFO_AFULL_EN
  ,
  output logic              o_afull
`endif
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, rd_ok, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  // A read frees the slot in the same cycle, so a full FIFO still takes a write paired with a read.
  assign rd_ok = i_rd && !empty;
  assign wr_ok = i_wr && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // A dropped byte takes priority over a clear request in the same cycle.
    if (i_wr && !wr_ok) ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= i_data;
  end

  // Head is forced to zero while empty so reset shows a defined value without clearing storage.
  assign o_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

`ifdef UART_RX_FIFO_AFULL_EN
  logic afull_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) afull_q <= 1'b0;
    else          afull_q <= (count_d >= (ADDR_W+1)'(AFULL_LVL));
  end

  assign o_afull = afull_q;
`endif

endmodule
